// File: rtl/udp_hdmi_send_pkg.sv
// Shared types and field positions for the stream transmitter and receiver.
package udp_hdmi_send_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_REQ,
    ST_SEND,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    HW_DST_IP,
    HW_PORTS,
    HW_ZERO,
    HW_LEN,
    HW_OFFSET
  } hdr_word_e;

  localparam int unsigned HDR_WORDS    = 5;
  localparam int unsigned CMD_W        = 40;
  localparam int unsigned CMD_LEN_MSB  = 39;
  localparam int unsigned CMD_LEN_LSB  = 32;
  localparam int unsigned CMD_ADDR_MSB = 31;
  localparam int unsigned CMD_ADDR_LSB = 0;

  function automatic logic [CMD_W-1:0] pack_cmd(input logic [7:0] len, input logic [31:0] addr);
    logic [CMD_W-1:0] c;
    c = '0;
    c[CMD_LEN_MSB:CMD_LEN_LSB]   = len;
    c[CMD_ADDR_MSB:CMD_ADDR_LSB] = addr;
    return c;
  endfunction

endpackage

// File: rtl/udp_hdmi_send_if.sv
// UDP send port plus DRAM read command / read-FIFO port of the transmitter.
interface udp_hdmi_send_if;
  logic                               w_req;
  logic                               w_ack;
  logic                               w_enable;
  logic [31:0]                        w_data;
  logic [udp_hdmi_send_pkg::CMD_W-1:0] ctrl_out;
  logic                               ctrl_we;
  logic [31:0]                        rd_data;
  logic                               rd_empty;
  logic                               rd_re;

  modport master (
    output w_req, w_enable, w_data, ctrl_out, ctrl_we, rd_re,
    input  w_ack, rd_data, rd_empty
  );

  modport slave (
    input  w_req, w_enable, w_data, ctrl_out, ctrl_we, rd_re,
    output w_ack, rd_data, rd_empty
  );
endinterface

// File: rtl/udp_send_pkt_buf.sv
// Synchronous FWFT FIFO holding one packet payload.
module udp_send_pkt_buf #(
  parameter  int unsigned DEPTH = 256,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok, rd_ok;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    wr_ok    = wr_en && !full;
    rd_ok    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_ok);
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
    count    = count_q;
    rd_data  = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/udp_hdmi_send.sv
// Frame transmitter: bursts a DRAM word range into a packet buffer, then
// emits it as UDP packets of header + word offset + payload.
module udp_hdmi_send
  import udp_hdmi_send_pkg::*;
#(
  parameter int unsigned PKT_WORDS   = 256,
  parameter int unsigned BURST_WORDS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      start_offset,
  input  logic [31:0]      start_words,
  input  logic [31:0]      dst_ip,
  input  logic [15:0]      src_port,
  input  logic [15:0]      dst_port,
  output logic             busy,
  output logic             done,
  udp_hdmi_send_if.master  bus
);
  localparam int unsigned CW = $clog2(PKT_WORDS) + 1;
  localparam int unsigned IW = CW + 1;

  function automatic logic [CW-1:0] pkt_len(input logic [31:0] rem);
    return (rem >= 32'(PKT_WORDS)) ? CW'(PKT_WORDS) : CW'(rem);
  endfunction

  state_e         state_q, state_d;
  logic [31:0]    offset_q, offset_d;
  logic [31:0]    remain_q, remain_d;
  logic [31:0]    dst_ip_q, dst_ip_d;
  logic [31:0]    ports_q, ports_d;
  logic [CW-1:0]  pkt_n_q, pkt_n_d;
  logic [CW-1:0]  cmd_left_q, cmd_left_d;
  logic [31:0]    cmd_addr_q, cmd_addr_d;
  logic [IW-1:0]  word_idx_q, word_idx_d;

  logic           buf_we, buf_re, buf_full, buf_empty;
  logic [31:0]    buf_rdata;
  logic [CW-1:0]  buf_count, cnt_next;
  logic [7:0]     cmd_len;
  logic           rd_pop;
  logic [31:0]    off_n, rem_n;

  udp_send_pkt_buf #(
    .DEPTH (PKT_WORDS),
    .WIDTH (32)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_we),
    .wr_data (bus.rd_data),
    .rd_en   (buf_re),
    .rd_data (buf_rdata),
    .count   (buf_count),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    remain_d     = remain_q;
    dst_ip_d     = dst_ip_q;
    ports_d      = ports_q;
    pkt_n_d      = pkt_n_q;
    cmd_left_d   = cmd_left_q;
    cmd_addr_d   = cmd_addr_q;
    word_idx_d   = word_idx_q;
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    bus.w_req    = 1'b0;
    bus.w_enable = 1'b0;
    bus.w_data   = '0;
    bus.ctrl_out = '0;
    bus.ctrl_we  = 1'b0;
    bus.rd_re    = 1'b0;
    buf_we       = 1'b0;
    buf_re       = 1'b0;
    rd_pop       = 1'b0;
    cnt_next     = buf_count;
    off_n        = offset_q + 32'(pkt_n_q);
    rem_n        = remain_q - 32'(pkt_n_q);
    cmd_len      = (cmd_left_q >= CW'(BURST_WORDS)) ? 8'(BURST_WORDS) : 8'(cmd_left_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          offset_d   = start_offset;
          remain_d   = start_words;
          dst_ip_d   = dst_ip;
          ports_d    = {src_port, dst_port};
          pkt_n_d    = pkt_len(start_words);
          cmd_left_d = pkt_len(start_words);
          cmd_addr_d = {start_offset[29:0], 2'b00};
          state_d    = (start_words == '0) ? ST_DONE : ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (cmd_left_q != '0) begin
          bus.ctrl_we  = 1'b1;
          bus.ctrl_out = pack_cmd(cmd_len, cmd_addr_q);
          cmd_left_d   = cmd_left_q - CW'(cmd_len);
          cmd_addr_d   = cmd_addr_q + 32'(BURST_WORDS * 4);
        end
        rd_pop    = !bus.rd_empty && !buf_full && (buf_count != pkt_n_q);
        bus.rd_re = rd_pop;
        buf_we    = rd_pop;
        cnt_next  = buf_count + CW'(rd_pop);
        // Leave on the edge of the last pop so w_req rises the cycle after.
        if (cnt_next == pkt_n_q && cmd_left_d == '0) begin
          state_d    = ST_REQ;
          word_idx_d = '0;
        end
      end

      ST_REQ: begin
        bus.w_req = 1'b1;
        if (bus.w_ack) state_d = ST_SEND;
      end

      ST_SEND: begin
        bus.w_enable = 1'b1;
        if (word_idx_q < IW'(HDR_WORDS)) begin
          case (hdr_word_e'(word_idx_q[2:0]))
            HW_DST_IP: bus.w_data = dst_ip_q;
            HW_PORTS:  bus.w_data = ports_q;
            HW_ZERO:   bus.w_data = '0;
            HW_LEN:    bus.w_data = (32'(pkt_n_q) + 32'd1) << 2;
            HW_OFFSET: bus.w_data = offset_q;
            default:   bus.w_data = '0;
          endcase
        end else begin
          bus.w_data = buf_rdata;
          buf_re     = !buf_empty;
        end

        if (word_idx_q == IW'(pkt_n_q) + IW'(HDR_WORDS - 1)) begin
          offset_d   = off_n;
          remain_d   = rem_n;
          word_idx_d = '0;
          if (rem_n == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_FETCH;
            pkt_n_d    = pkt_len(rem_n);
            cmd_left_d = pkt_len(rem_n);
            cmd_addr_d = {off_n[29:0], 2'b00};
          end
        end else begin
          word_idx_d = word_idx_q + 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      offset_q   <= '0;
      remain_q   <= '0;
      dst_ip_q   <= '0;
      ports_q    <= '0;
      pkt_n_q    <= '0;
      cmd_left_q <= '0;
      cmd_addr_q <= '0;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      remain_q   <= remain_d;
      dst_ip_q   <= dst_ip_d;
      ports_q    <= ports_d;
      pkt_n_q    <= pkt_n_d;
      cmd_left_q <= cmd_left_d;
      cmd_addr_q <= cmd_addr_d;
      word_idx_q <= word_idx_d;
    end
  end
endmodule
